shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult.sv | 99 +++++++++
 tb/tb_shift_add_mult.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential signed shift-and-add multiplier, one multiplier bit per cycle
// Sign bit of the multiplier carries negative weight, so the last step subtracts.
module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_d;
  logic [AW-1:0]    a_q;
  logic [AW-1:0]    term;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             exc_d;
  logic             rdy_q;
  logic             busy_q;
  logic             last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign term     = a_q << cnt_q;

  always_comb begin
    acc_d = acc_q;
    if (b_q[cnt_q]) begin
      acc_d = last_bit ? (acc_q - term) : (acc_q + term);
    end
  end

  // Product fits only if the upper half is a pure sign extension of the lower half.
  assign exc_d = (acc_d[AW-1:WIDTH] != {WIDTH{acc_d[WIDTH-1]}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_MULT) begin
        a_q     <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        b_q     <= data_operandB;
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
              state_q  <= DONE;
              result_q <= acc_d[WIDTH-1:0];
              exc_q    <= exc_d;
              rdy_q    <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - self-checking bench for shift_add_mult against an arithmetic product model
module tb_shift_add_mult;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int          total;
  int          bad;
  int          cyc;
  int          rdy_n;
  int          last_rdy;
  logic [31:0] cap_result;
  logic        cap_exc;
  logic        busy_ok;

  shift_add_mult #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    model = {(p != {{32{p[31]}}, p[31:0]}), p[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, log any ready pulse, scramble idle operands.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (data_resultRDY === 1'b1) begin
      rdy_n++;
      last_rdy   = cyc;
      cap_result = data_result;
      cap_exc    = data_exception;
    end
    if (!ctrl_MULT) begin
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    tick();
    cyc           = 0;
    rdy_n         = 0;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    tick();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e;
    e       = model(a, b);
    busy_ok = (busy === 1'b1);
    while (cyc < 34) begin
      tick();
      if (busy !== (cyc <= 33)) busy_ok = 1'b0;
    end
    check({tag, "_rdy_count"}, 64'(rdy_n), 64'd1);
    check({tag, "_rdy_cycle"}, 64'(last_rdy), 64'd33);
    check({tag, "_result"}, {32'd0, cap_result}, {32'd0, e[31:0]});
    check({tag, "_exc"}, {63'd0, cap_exc}, {63'd0, e[32]});
    check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    total = 0; bad = 0; cyc = 0; rdy_n = 0; last_rdy = -1;
    cap_result = '0; cap_exc = 1'b0; busy_ok = 1'b1;
    reset_n = 1'b0; ctrl_MULT = 1'b0;
    data_operandA = '0; data_operandB = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {29'd0, data_result, data_exception, data_resultRDY, busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_n = 0;
    repeat (5) tick();
    check("idle_after_reset_busy", {63'd0, busy}, 64'd0);
    check("idle_after_reset_rdy", 64'(rdy_n), 64'd0);

    start(32'd7, 32'd6);                       finish_op("mul_7x6", 32'd7, 32'd6);
    check("mul_7x6_const", {32'd0, cap_result}, 64'd42);
    start(32'hFFFF_FFFD, 32'd5);               finish_op("mul_m3x5", 32'hFFFF_FFFD, 32'd5);
    check("mul_m3x5_const", {32'd0, cap_result}, 64'hFFFF_FFF1);
    start(32'h8000_0000, 32'hFFFF_FFFF);       finish_op("mul_min_xm1", 32'h8000_0000, 32'hFFFF_FFFF);
    check("mul_min_xm1_exc", {63'd0, cap_exc}, 64'd1);
    start(32'h0001_0000, 32'h0001_0000);       finish_op("mul_2p16sq", 32'h0001_0000, 32'h0001_0000);
    start(32'h7FFF_FFFF, 32'd1);               finish_op("mul_max_x1", 32'h7FFF_FFFF, 32'd1);
    start(32'd1000, 32'hFFFF_FC18);            finish_op("mul_1000xm1000", 32'd1000, 32'hFFFF_FC18);
    check("mul_1000xm1000_const", {32'd0, cap_result}, 64'h0000_0000_FFF0_BDC0);
    check("hold_after_done", {32'd0, data_result}, 64'h0000_0000_FFF0_BDC0);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
      start(ra, rb);
      finish_op($sformatf("rand%0d", k), ra, rb);
    end

    // Restart mid-run: the first operation must never report.
    start(32'd2, 32'd3);
    while (cyc < 10) tick();
    data_operandA = 32'd4; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    while (cyc < 44) tick();
    check("restart_rdy_count", 64'(rdy_n), 64'd1);
    check("restart_rdy_cycle", 64'(last_rdy), 64'd43);
    check("restart_result", {32'd0, cap_result}, 64'd20);

    // New start in the DONE cycle: both the old ready pulse and the new operation happen.
    start(32'hFFFF_FF00, 32'd300);
    while (cyc < 33) tick();
    check("done_restart_old_rdy", 64'(rdy_n), 64'd1);
    check("done_restart_old_res", {32'd0, cap_result}, {32'd0, model(32'hFFFF_FF00, 32'd300) & 33'h0_FFFF_FFFF});
    cyc = 0; rdy_n = 0;
    data_operandA = 32'h0001_2345; data_operandB = 32'hFFFE_0001; ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    finish_op("done_restart_new", 32'h0001_2345, 32'hFFFE_0001);

    // Asynchronous reset mid-run.
    start(32'd123, 32'd456);
    while (cyc < 15) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {29'd0, data_result, data_exception, data_resultRDY, busy}, 64'd0);
    while (cyc < 17) tick();
    reset_n = 1'b1;
    rdy_n = 0;
    while (cyc < 60) tick();
    check("post_reset_no_rdy", 64'(rdy_n), 64'd0);
    check("post_reset_idle", {63'd0, busy}, 64'd0);
    start(32'd9, 32'd9);                       finish_op("mul_9x9", 32'd9, 32'd9);
    check("mul_9x9_const", {32'd0, cap_result}, 64'd81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
